// File: rtl/ysyx_24090003_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings, the sequential PC step and the reset PC.
package ysyx_24090003_ifu_pkg;

  typedef enum logic [2:0] {
    IFU_S_REQ    = 3'd0,
    IFU_S_WAIT   = 3'd1,
    IFU_S_VALID  = 3'd2,
    IFU_S_COMMIT = 3'd3,
    IFU_S_ERR    = 3'd4
  } ifu_state_e;

  localparam logic [31:0] CONSTANT_FOUR    = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24090003_ifu_pc_reg.sv
// Architectural PC register with redirect/+4 next-PC select.
// YSYX_24090003_IFU_MISALIGN_CHECK_EN: keep raw redirect target and flag misalignment.
module ysyx_24090003_ifu_pc_reg
  import ysyx_24090003_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_pc_update,
  input  logic [ADDR_W-1:0] i_next_pc,
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
  output logic              o_misalign,
`endif
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redirect, sel_pc;

  always_comb begin
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
    redirect = i_next_pc;
`else
    redirect = i_next_pc & ~ADDR_W'(2'b11);
`endif
    sel_pc = i_pc_update ? redirect : pc_q + ADDR_W'(CONSTANT_FOUR);
    pc_d   = i_load ? sel_pc : pc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
  assign o_misalign = is_misaligned(sel_pc[1:0]);
`endif
  assign o_pc = pc_q;

endmodule

// File: rtl/ysyx_24090003_ifu.sv
// Instruction fetch unit: single-outstanding imem fetch, IDU handshake, PC update on commit.
// YSYX_24090003_IFU_MISALIGN_CHECK_EN adds o_fetch_err and a sticky error state.
module ysyx_24090003_ifu
  import ysyx_24090003_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_resp_valid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_commit,
  input  logic              i_pc_update,
  input  logic [ADDR_W-1:0] i_next_pc,
  output logic              o_busy
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
  ,
  output logic              o_fetch_err
`endif
);

  ifu_state_e        state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              req_valid_q, req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic              busy_q, busy_d;
  logic              pc_load;
  logic [ADDR_W-1:0] pc;
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
  logic              misalign;
  logic              err_q, err_d;
`endif

  ysyx_24090003_ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (pc_load),
    .i_pc_update (i_pc_update),
    .i_next_pc   (i_next_pc),
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
    .o_misalign  (misalign),
`endif
    .o_pc        (pc)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_load = 1'b0;
    case (state_q)
      IFU_S_REQ:    if (i_imem_req_ready) state_d = IFU_S_WAIT;
      IFU_S_WAIT: begin
        if (i_imem_resp_valid) begin
          inst_d  = i_imem_rdata;
          state_d = IFU_S_VALID;
        end
      end
      IFU_S_VALID:  if (i_inst_ready) state_d = IFU_S_COMMIT;
      IFU_S_COMMIT: begin
        if (i_commit) begin
          pc_load = 1'b1;
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
          state_d = misalign ? IFU_S_ERR : IFU_S_REQ;
`else
          state_d = IFU_S_REQ;
`endif
        end
      end
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
      IFU_S_ERR:    state_d = IFU_S_ERR;
`endif
      default:      state_d = IFU_S_REQ;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    req_valid_d  = (state_d == IFU_S_REQ);
    inst_valid_d = (state_d == IFU_S_VALID);
    busy_d       = (state_d != IFU_S_REQ);
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
    err_d        = (state_d == IFU_S_ERR);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IFU_S_REQ;
      inst_q       <= '0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      busy_q       <= busy_d;
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  // Everything but the PC reads zero while reset is held.
  assign o_imem_req_valid = req_valid_q & ~i_rst;
  assign o_inst_valid     = inst_valid_q & ~i_rst;
  assign o_busy           = busy_q & ~i_rst;
  assign o_inst           = inst_q & {INST_W{~i_rst}};
  assign o_imem_addr      = pc;
  assign o_pc             = pc;
`ifdef YSYX_24090003_IFU_MISALIGN_CHECK_EN
  assign o_fetch_err      = err_q & ~i_rst;
`endif

endmodule

// File: doc/ysyx_24090003_ifu.md
Name: ysyx_24090003_ifu

Overview:
Instruction fetch unit for the multi-cycle ysyx_24090003 core. Holds the architectural PC and issues one instruction-memory read at a time over a valid/ready request and valid response bus. Presents the fetched instruction and its PC to IDU with a valid/ready handshake. Updates the PC when the commit pulse arrives, using the EXU's next-PC/update outputs (i_next_pc, i_pc_update).

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
ADDR_W, 32, PC/address width.
INST_W, 32, instruction width.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous active-high reset
o_imem_req_valid  out  1  fetch request valid
i_imem_req_ready  in  1  memory accepts request
o_imem_addr  out  ADDR_W  fetch address, equals o_pc
i_imem_resp_valid  in  1  read data valid, one-cycle pulse
i_imem_rdata  in  INST_W  read data
o_inst_valid  out  1  instruction valid toward IDU
i_inst_ready  in  1  IDU accepts instruction
o_inst  out  INST_W  fetched instruction, registered
o_pc  out  ADDR_W  PC of the held instruction
i_commit  in  1  one-cycle pulse: the instruction has finished execute/writeback
i_pc_update  in  1  EXU redirect enable, sampled with i_commit
i_next_pc  in  ADDR_W  EXU redirect target, sampled with i_commit
o_busy  out  1  high in every state except S_REQ

Behaviour:
- Reset (sync, i_rst=1 at edge): pc<=RESET_PC, inst<=0, state<=S_REQ. All outputs except o_pc/o_imem_addr read 0 in the reset cycle.
- FSM states: S_REQ, S_WAIT, S_VALID, S_COMMIT.
- S_REQ: o_imem_req_valid=1, o_busy=0. On i_imem_req_ready=1, go to S_WAIT. Holding valid with no ready stays in S_REQ, and the address stays stable.
- S_WAIT: on i_imem_resp_valid=1, inst<=i_imem_rdata and go to S_VALID. A response in the same cycle as the accepting request is not permitted by the bus. The earliest response comes one cycle after acceptance.
- S_VALID: o_inst_valid=1. o_inst and o_pc are stable until the handshake completes. On i_inst_ready=1, go to S_COMMIT.
- S_COMMIT: wait for i_commit.
  - i_commit && i_pc_update: pc<=i_next_pc.
  - i_commit && !i_pc_update: pc<=pc+4 (ADDR_W-bit modulo wrap, 32'hFFFF_FFFC+4 = 0).
  - Then go to S_REQ.
- i_commit outside S_COMMIT is ignored (no PC change).
- Minimum loop latency: commit to next request valid is 1 cycle. Request accept to o_inst_valid is at least 2 cycles.
- A spurious i_imem_resp_valid in any state other than S_WAIT is ignored.
- Reset mid-operation (any state) aborts the fetch. A response arriving after reset is ignored because the FSM is in S_REQ.
- One outstanding fetch at most. No speculation, no flush input: redirects arrive only via commit.

Optional Feature:
Macro YSYX_24090003_IFU_MISALIGN_CHECK_EN.
- Defined:
  - At commit, if the selected next PC has bits [1:0]!=0, enter sticky state S_ERR.
  - Add output o_fetch_err (1 bit), which reads 1 in S_ERR.
  - No further requests are issued and o_inst_valid=0.
  - Only reset leaves S_ERR. pc still loads the misaligned value for debug visibility.
- Undefined:
  - Bits [1:0] of i_next_pc are forced to 00 when loaded.
  - No o_fetch_err port and no S_ERR state.

Decomposition:
- Shared package/define file ysyx_24090003_define.v:
  - IFU state encodings IFU_S_REQ/WAIT/VALID/COMMIT/ERR (3 bits).
  - Constant CONSTANT_FOUR, reused for the sequential increment.
  - RESET_PC default constant.
- Sub-module: ysyx_24090003_pc_reg, which holds the PC register, reset load, next-PC mux (redirect/+4) and the misalign check. The FSM stays in the top.

Test Plan:
- Reset then memory ready immediately, response 1 cycle later with rdata=32'h0000_0013 -> o_imem_addr=32'h8000_0000; o_inst_valid rises 2 cycles after acceptance with o_inst=32'h0000_0013, o_pc=32'h8000_0000.
- Sequential: commit with i_pc_update=0 -> next request address 32'h8000_0004, issued 1 cycle after commit.
- Redirect: commit with i_pc_update=1, i_next_pc=32'h8000_0100 -> next o_imem_addr=32'h8000_0100. Same-cycle i_next_pc change without i_commit -> no effect.
- Backpressure: i_imem_req_ready low 5 cycles, then i_inst_ready low 3 cycles -> request valid/address held 5 cycles; o_inst/o_pc stable 3 cycles; exactly one commit-wait per instruction.
- Reset in S_WAIT, then stale response pulse -> state S_REQ at RESET_PC; stale data not latched; fresh request issued.
- With YSYX_24090003_IFU_MISALIGN_CHECK_EN: redirect to 32'h8000_0102 -> o_fetch_err=1 next cycle, no further requests until reset. Without the macro: the fetch goes to 32'h8000_0100.
